uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between `CHANNELS` byte requesters. It sits between client logic (command responders, debug printers, status reporters) and the UART TX block. It accepts one byte at a time from the winning requester, issues the transmitter's start pulse and waits for its done pulse. An optional per-byte lock keeps ownership across a multi-byte message so that messages from different clients never interleave on the line.

---
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among CHANNELS byte requesters,
// with an optional per-byte lock that keeps ownership across a multi-byte message.
module uart_tx_arbiter #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned LOCK_TIMEOUT = 1000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [CHANNELS-1:0]   Req_i,
    input  logic [8*CHANNELS-1:0] Data_i,
    input  logic [CHANNELS-1:0]   Lock_i,
    output logic [CHANNELS-1:0]   Ack_o,
    output logic [CHANNELS-1:0]   Grant_o,
    output logic                  TxStart_o,
    output logic [7:0]            TxData_o,
    input  logic                  TxBusy_i,
    input  logic                  TxDone_i
);

    localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t          state;
    logic [PW-1:0]   last;
    logic            lock_q;
    logic [TW-1:0]   lock_timer;

    logic            win_valid_c;
    logic [PW-1:0]   win_idx_c;
    logic [7:0]      win_data_c;
    logic            owner_idle_c;

    // Winner selection: the locked owner only, otherwise first requester after last.
    always_comb begin
        logic [PW-1:0] cand;
        cand        = '0;
        win_valid_c = 1'b0;
        win_idx_c   = last;
        if (lock_q) begin
            win_valid_c = Req_i[last];
        end else begin
            // Walk from the farthest offset down so the nearest requester wins.
            for (int i = int'(CHANNELS); i >= 1; i--) begin
                cand = PW'((int'(last) + i) % int'(CHANNELS));
                if (Req_i[cand]) begin
                    win_valid_c = 1'b1;
                    win_idx_c   = cand;
                end
            end
        end
    end

    always_comb begin
        win_data_c = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (win_idx_c == PW'(c)) begin
                win_data_c = Data_i[8*c +: 8];
            end
        end
    end

    assign owner_idle_c = (state == IDLE) && lock_q && !Req_i[last];

    // Arbitration FSM with registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            last       <= PW'(CHANNELS - 1);
            lock_q     <= 1'b0;
            lock_timer <= '0;
            Ack_o      <= '0;
            Grant_o    <= '0;
            TxStart_o  <= 1'b0;
            TxData_o   <= 8'h00;
        end else begin
            Ack_o      <= '0;
            TxStart_o  <= 1'b0;
            lock_timer <= '0;
            case (state)
                IDLE: begin
                    if (owner_idle_c) begin
                        // Owner went quiet: drop the lock after LOCK_TIMEOUT idle cycles.
                        if (lock_timer >= TW'(LOCK_TIMEOUT - 1)) begin
                            lock_q  <= 1'b0;
                            Grant_o <= '0;
                        end else begin
                            lock_timer <= lock_timer + 1'b1;
                        end
                    end else if (!TxBusy_i && win_valid_c) begin
                        TxData_o  <= win_data_c;
                        Grant_o   <= CHANNELS'(1) << win_idx_c;
                        Ack_o     <= CHANNELS'(1) << win_idx_c;
                        TxStart_o <= 1'b1;
                        last      <= win_idx_c;
                        lock_q    <= Lock_i[win_idx_c];
                        state     <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (TxDone_i) begin
                        state <= IDLE;
                        if (!lock_q) begin
                            Grant_o <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, fairness, locking, timeout, busy hold-off.
module tb_uart_tx_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  Req_i;
    logic [31:0] Data_i;
    logic [3:0]  Lock_i;
    logic [3:0]  Ack_o;
    logic [3:0]  Grant_o;
    logic        TxStart_o;
    logic [7:0]  TxData_o;
    logic        TxBusy_i;
    logic        TxDone_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    uart_tx_arbiter #(.CHANNELS(4), .LOCK_TIMEOUT(8)) dut (
        .Clock(Clock), .Reset(Reset), .Req_i(Req_i), .Data_i(Data_i), .Lock_i(Lock_i),
        .Ack_o(Ack_o), .Grant_o(Grant_o), .TxStart_o(TxStart_o), .TxData_o(TxData_o),
        .TxBusy_i(TxBusy_i), .TxDone_i(TxDone_i)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Transmitter completion pulse in the current cycle; returns one cycle later.
    task automatic tx_done();
        TxDone_i = 1'b1;
        tick();
        TxDone_i = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Req_i = 4'hF; Lock_i = 4'h0; Data_i = 32'h13121110;
        TxBusy_i = 1'b0; TxDone_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({Ack_o, Grant_o, TxStart_o, TxData_o} !== 17'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got ack=%b grant=%b start=%b data=%h exp all zero",
                         k, Ack_o, Grant_o, TxStart_o, TxData_o);
            end
        end
        Reset = 1'b0;
        tick();
        n_checks++;
        if ({Ack_o, TxStart_o, TxData_o, Grant_o} !== {4'b0001, 1'b1, 8'h10, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_first_grant: got ack=%b start=%b data=%h grant=%b exp 0001 1 10 0001",
                     Ack_o, TxStart_o, TxData_o, Grant_o);
        end
        Req_i = 4'h0;
        tick();
        n_checks++;
        if ({Ack_o, TxStart_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulse_width: got ack=%b start=%b exp 0000 0", Ack_o, TxStart_o);
        end
        tx_done();
        n_checks++;
        if (Grant_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: got grant=%b exp 0000", Grant_o);
        end
    endtask

    task automatic test_single_byte();
        Req_i = 4'b0100; Data_i = 32'h00A50000;
        tick();
        n_checks++;
        if ({Ack_o, TxStart_o, TxData_o, Grant_o} !== {4'b0100, 1'b1, 8'hA5, 4'b0100}) begin
            n_fail++;
            $display("FAIL single_accept: got ack=%b start=%b data=%h grant=%b exp 0100 1 a5 0100",
                     Ack_o, TxStart_o, TxData_o, Grant_o);
        end
        Req_i = 4'h0; Data_i = 32'h0;
        TxBusy_i = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({TxData_o, Grant_o, TxStart_o} !== {8'hA5, 4'b0100, 1'b0}) begin
            n_fail++;
            $display("FAIL single_hold: got data=%h grant=%b start=%b exp a5 0100 0",
                     TxData_o, Grant_o, TxStart_o);
        end
        TxBusy_i = 1'b0;
        tx_done();
        n_checks++;
        if (Grant_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_release: got grant=%b exp 0000", Grant_o);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_data;
        logic [3:0] exp_ack;
        Req_i = 4'h0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0; Req_i = 4'hF; Data_i = 32'h13121110;
        tick();
        n_checks++;
        if ({TxStart_o, TxData_o, Ack_o} !== {1'b1, 8'h10, 4'b0001}) begin
            n_fail++;
            $display("FAIL fair_first: got start=%b data=%h ack=%b exp 1 10 0001",
                     TxStart_o, TxData_o, Ack_o);
        end
        for (int i = 1; i <= 4; i++) begin
            exp_data = 8'h10 + 8'(i % 4);
            exp_ack  = 4'(1 << (i % 4));
            tick();
            tx_done();
            n_checks++;
            if (TxStart_o !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_gap[%0d]: got start=%b exp 0 one cycle after done", i, TxStart_o);
            end
            tick();
            n_checks++;
            if ({TxStart_o, TxData_o, Ack_o} !== {1'b1, exp_data, exp_ack}) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got start=%b data=%h ack=%b exp 1 %h %b",
                         i, TxStart_o, TxData_o, Ack_o, exp_data, exp_ack);
            end
        end
        Req_i = 4'h0;
        tick();
        tx_done();
    endtask

    task automatic test_locked_message();
        Req_i = 4'b0011; Data_i = 32'h0000B1C0; Lock_i = 4'b0010;
        tick();
        n_checks++;
        if ({Ack_o, TxData_o, TxStart_o} !== {4'b0010, 8'hB1, 1'b1}) begin
            n_fail++;
            $display("FAIL lock_byte1: got ack=%b data=%h start=%b exp 0010 b1 1", Ack_o, TxData_o, TxStart_o);
        end
        Data_i = 32'h0000B2C0;
        tick();
        tx_done();
        n_checks++;
        if ({Grant_o, Ack_o} !== {4'b0010, 4'b0000}) begin
            n_fail++;
            $display("FAIL lock_keep: got grant=%b ack=%b exp 0010 0000", Grant_o, Ack_o);
        end
        tick();
        n_checks++;
        if ({Ack_o, TxData_o} !== {4'b0010, 8'hB2}) begin
            n_fail++;
            $display("FAIL lock_byte2: got ack=%b data=%h exp 0010 b2", Ack_o, TxData_o);
        end
        Data_i = 32'h0000B3C0; Lock_i = 4'b0000;
        tick();
        tx_done();
        tick();
        n_checks++;
        if ({Ack_o, TxData_o} !== {4'b0010, 8'hB3}) begin
            n_fail++;
            $display("FAIL lock_byte3: got ack=%b data=%h exp 0010 b3", Ack_o, TxData_o);
        end
        Req_i = 4'b0001;
        tick();
        tx_done();
        n_checks++;
        if (Grant_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL lock_release: got grant=%b exp 0000", Grant_o);
        end
        tick();
        n_checks++;
        if ({Ack_o, TxData_o} !== {4'b0001, 8'hC0}) begin
            n_fail++;
            $display("FAIL lock_next_owner: got ack=%b data=%h exp 0001 c0", Ack_o, TxData_o);
        end
        Req_i = 4'h0;
        tick();
        tx_done();
    endtask

    task automatic test_lock_timeout();
        Req_i = 4'b1001; Data_i = 32'hD30000C1; Lock_i = 4'b1000;
        tick();
        n_checks++;
        if ({Ack_o, TxData_o} !== {4'b1000, 8'hD3}) begin
            n_fail++;
            $display("FAIL tmo_accept: got ack=%b data=%h exp 1000 d3", Ack_o, TxData_o);
        end
        Req_i = 4'b0001;
        tick();
        tx_done();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick();
            n_checks++;
            if ({Grant_o, Ack_o} !== {4'b1000, 4'b0000}) begin
                n_fail++;
                $display("FAIL tmo_hold[%0d]: got grant=%b ack=%b exp 1000 0000", k, Grant_o, Ack_o);
            end
        end
        tick();
        n_checks++;
        if ({Grant_o, Ack_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL tmo_drop: got grant=%b ack=%b exp 0000 0000", Grant_o, Ack_o);
        end
        tick();
        n_checks++;
        if ({Ack_o, TxData_o, Grant_o} !== {4'b0001, 8'hC1, 4'b0001}) begin
            n_fail++;
            $display("FAIL tmo_next: got ack=%b data=%h grant=%b exp 0001 c1 0001", Ack_o, TxData_o, Grant_o);
        end
        Req_i = 4'h0; Lock_i = 4'h0;
        tick();
        tx_done();
    endtask

    task automatic test_reset_busy();
        Req_i = 4'b0100; Data_i = 32'h005A0077;
        tick();
        n_checks++;
        if (Ack_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstb_accept: got ack=%b exp 0100", Ack_o);
        end
        Req_i = 4'h0; TxBusy_i = 1'b1;
        tick(); tick();
        Reset = 1'b1; Req_i = 4'b0001;
        tick();
        n_checks++;
        if ({Ack_o, Grant_o, TxStart_o, TxData_o} !== 17'h0) begin
            n_fail++;
            $display("FAIL rstb_clear: got ack=%b grant=%b start=%b data=%h exp all zero",
                     Ack_o, Grant_o, TxStart_o, TxData_o);
        end
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({Ack_o, Grant_o, TxStart_o} !== 9'h0) begin
                n_fail++;
                $display("FAIL rstb_busy[%0d]: got ack=%b grant=%b start=%b exp 0000 0000 0",
                         k, Ack_o, Grant_o, TxStart_o);
            end
        end
        TxBusy_i = 1'b0;
        tick();
        n_checks++;
        if ({Ack_o, TxStart_o, TxData_o} !== {4'b0001, 1'b1, 8'h77}) begin
            n_fail++;
            $display("FAIL rstb_grant: got ack=%b start=%b data=%h exp 0001 1 77", Ack_o, TxStart_o, TxData_o);
        end
        Req_i = 4'h0;
        tick();
        tx_done();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fairness();
        test_locked_message();
        test_lock_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
